// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data requesters; data has priority, fetch wins after STARVE_LIMIT losses.
// Reads answer MEM_LATENCY+1 cycles after grant, stores ack next cycle; requests wait with gnt low while busy.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic                  if_gnt_o,
   output logic                  if_rvalid_o,
   output logic [DATA_WIDTH-1:0] if_rdata_o,
   input  logic                  dm_req_i,
   input  logic                  dm_we_i,
   input  logic [ADDR_WIDTH-1:0] dm_addr_i,
   input  logic [DATA_WIDTH-1:0] dm_wdata_i,
   output logic                  dm_gnt_o,
   output logic                  dm_rvalid_o,
   output logic [DATA_WIDTH-1:0] dm_rdata_o,
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  busy_o
);
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam int LAT_W    = $clog2(MEM_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_ACK} state_t;

   state_t                state;
   logic [LAT_W-1:0]      latCnt;
   logic [STARVE_W-1:0]   starveCnt;
   logic                  fetchOwner;
   logic                  ifRvalid;
   logic                  dmRvalid;
   logic [DATA_WIDTH-1:0] ifRdata;
   logic [DATA_WIDTH-1:0] dmRdata;
   logic                  starved;
   logic                  ifWin;
   logic                  dmWin;

   // Grants only from IDLE and never while reset is asserted.
   always_comb begin
      starved = (starveCnt == STARVE_W'(STARVE_LIMIT));
      ifWin   = 1'b0;
      dmWin   = 1'b0;
      if (state == IDLE && !rst_i) begin
         ifWin = if_req_i && (!dm_req_i || starved);
         dmWin = dm_req_i && !ifWin;
      end
   end

   assign if_gnt_o    = ifWin;
   assign dm_gnt_o    = dmWin;
   assign mem_en_o    = ifWin | dmWin;
   assign mem_we_o    = dmWin & dm_we_i;
   assign mem_addr_o  = ifWin ? if_addr_i : (dmWin ? dm_addr_i : '0);
   assign mem_wdata_o = dmWin ? dm_wdata_i : '0;
   assign busy_o      = (state != IDLE);
   assign if_rvalid_o = ifRvalid;
   assign if_rdata_o  = ifRdata;
   assign dm_rvalid_o = dmRvalid;
   assign dm_rdata_o  = dmRdata;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         latCnt     <= '0;
         starveCnt  <= '0;
         fetchOwner <= 1'b0;
         ifRvalid   <= 1'b0;
         dmRvalid   <= 1'b0;
         ifRdata    <= '0;
         dmRdata    <= '0;
      end else begin
         ifRvalid <= 1'b0;
         dmRvalid <= 1'b0;
         case (state)
            IDLE: begin
               // A fetch loss in IDLE implies data won a contested arbitration.
               if (ifWin || !if_req_i) begin
                  starveCnt <= '0;
               end else if (dmWin) begin
                  starveCnt <= starveCnt + STARVE_W'(1);
               end
               if (dmWin && dm_we_i) begin
                  state    <= WR_ACK;
                  dmRvalid <= 1'b1;
               end else if (ifWin || dmWin) begin
                  state      <= RD_WAIT;
                  latCnt     <= LAT_W'(MEM_LATENCY - 1);
                  fetchOwner <= ifWin;
               end
            end
            RD_WAIT: begin
               if (latCnt == '0) begin
                  state <= IDLE;
                  if (fetchOwner) begin
                     ifRdata  <= mem_rdata_i;
                     ifRvalid <= 1'b1;
                  end else begin
                     dmRdata  <= mem_rdata_i;
                     dmRvalid <= 1'b1;
                  end
               end else begin
                  latCnt <= latCnt - LAT_W'(1);
               end
            end
            WR_ACK: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: instance A (latency 2) covers fetch, store, starvation and reset; instance B (latency 1) covers back-to-back loads.
module tb_mem_port_arbiter;
   localparam logic [31:0] JUNK = 32'hBADC0DE5;

   typedef struct {
      int          cyc;
      bit          isIf;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } gntExp_t;

   typedef struct {
      int          cyc;
      bit          isIf;
      logic [31:0] data;
   } rspExp_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   gntExp_t qGA[$];
   gntExp_t qGB[$];
   rspExp_t qRA[$];
   rspExp_t qRB[$];

   logic aRst, aIfReq, aIfGnt, aIfRvalid, aDmReq, aDmWe, aDmGnt, aDmRvalid, aMemEn, aMemWe, aBusy;
   logic [31:0] aIfAddr, aIfRdata, aDmAddr, aDmWdata, aDmRdata, aMemAddr, aMemWdata, aMemRdata;
   logic bRst, bIfReq, bIfGnt, bIfRvalid, bDmReq, bDmWe, bDmGnt, bDmRvalid, bMemEn, bMemWe, bBusy;
   logic [31:0] bIfAddr, bIfRdata, bDmAddr, bDmWdata, bDmRdata, bMemAddr, bMemWdata, bMemRdata;
   logic [31:0] aPipe0 = JUNK, aPipe1 = JUNK, bPipe0 = JUNK;
   logic [31:0] word40 = 32'h0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) dutA (
      .clk_i(clk), .rst_i(aRst),
      .if_req_i(aIfReq), .if_addr_i(aIfAddr), .if_gnt_o(aIfGnt), .if_rvalid_o(aIfRvalid), .if_rdata_o(aIfRdata),
      .dm_req_i(aDmReq), .dm_we_i(aDmWe), .dm_addr_i(aDmAddr), .dm_wdata_i(aDmWdata),
      .dm_gnt_o(aDmGnt), .dm_rvalid_o(aDmRvalid), .dm_rdata_o(aDmRdata),
      .mem_en_o(aMemEn), .mem_we_o(aMemWe), .mem_addr_o(aMemAddr), .mem_wdata_o(aMemWdata),
      .mem_rdata_i(aMemRdata), .busy_o(aBusy)
   );

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dutB (
      .clk_i(clk), .rst_i(bRst),
      .if_req_i(bIfReq), .if_addr_i(bIfAddr), .if_gnt_o(bIfGnt), .if_rvalid_o(bIfRvalid), .if_rdata_o(bIfRdata),
      .dm_req_i(bDmReq), .dm_we_i(bDmWe), .dm_addr_i(bDmAddr), .dm_wdata_i(bDmWdata),
      .dm_gnt_o(bDmGnt), .dm_rvalid_o(bDmRvalid), .dm_rdata_o(bDmRdata),
      .mem_en_o(bMemEn), .mem_we_o(bMemWe), .mem_addr_o(bMemAddr), .mem_wdata_o(bMemWdata),
      .mem_rdata_i(bMemRdata), .busy_o(bBusy)
   );

   function automatic logic [31:0] memRead(input logic [31:0] addr);
      case (addr)
         32'h100: return 32'hDEADBEEF;
         32'h104: return 32'h55556666;
         32'h200: return 32'h11112222;
         32'h300: return 32'h33334444;
         32'h080: return 32'hA0A0A0A0;
         32'h084: return 32'hB1B1B1B1;
         32'h040: return word40;
         default: return 32'h0;
      endcase
   endfunction

   // Fixed-latency memory stubs; read data is junk outside the valid cycle.
   always @(posedge clk) begin
      if (aMemEn && aMemWe && aMemAddr == 32'h40) word40 <= aMemWdata;
      aPipe0 <= (aMemEn && !aMemWe) ? memRead(aMemAddr) : JUNK;
      aPipe1 <= aPipe0;
      bPipe0 <= (bMemEn && !bMemWe) ? memRead(bMemAddr) : JUNK;
   end
   assign aMemRdata = aPipe1;
   assign bMemRdata = bPipe0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic at(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pushGnt(input int inst, input int c, input bit isIf, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata);
      gntExp_t e;
      e.cyc = c; e.isIf = isIf; e.we = we; e.addr = addr; e.wdata = wdata;
      if (inst == 0) qGA.push_back(e);
      else qGB.push_back(e);
   endtask

   task automatic pushRsp(input int inst, input int c, input bit isIf, input logic [31:0] data);
      rspExp_t e;
      e.cyc = c; e.isIf = isIf; e.data = data;
      if (inst == 0) qRA.push_back(e);
      else qRB.push_back(e);
   endtask

   task automatic monitor(input int inst, input logic ifG, input logic dmG, input logic en, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic ifRv, input logic dmRv,
                          input logic [31:0] ifRd, input logic [31:0] dmRd);
      gntExp_t g;
      rspExp_t r;
      string   tag;
      int      gLeft, rLeft;
      tag   = (inst == 0) ? "A" : "B";
      gLeft = (inst == 0) ? qGA.size() : qGB.size();
      rLeft = (inst == 0) ? qRA.size() : qRB.size();
      if (ifG || dmG) begin
         if (gLeft == 0) begin
            chk({tag, " unexpected gnt"}, 128'({ifG, dmG}), 128'(0));
         end else begin
            if (inst == 0) g = qGA.pop_front();
            else g = qGB.pop_front();
            chk({tag, " gnt cycle"}, 128'(cyc), 128'(g.cyc));
            chk({tag, " gnt/mem fields"}, 128'({ifG, dmG, en, we, addr, wdata}),
                128'({g.isIf, ~g.isIf, 1'b1, g.we, g.addr, g.wdata}));
         end
      end else begin
         chk({tag, " idle mem bus"}, 128'({en, we, addr, wdata}), 128'(0));
      end
      if (ifRv || dmRv) begin
         if (rLeft == 0) begin
            chk({tag, " unexpected rvalid"}, 128'({ifRv, dmRv}), 128'(0));
         end else begin
            if (inst == 0) r = qRA.pop_front();
            else r = qRB.pop_front();
            chk({tag, " rsp cycle"}, 128'(cyc), 128'(r.cyc));
            chk({tag, " rsp port"}, 128'({ifRv, dmRv}), 128'({r.isIf, ~r.isIf}));
            chk({tag, " rsp data"}, 128'(r.isIf ? ifRd : dmRd), 128'(r.data));
         end
      end
   endtask

   always @(negedge clk) begin
      monitor(0, aIfGnt, aDmGnt, aMemEn, aMemWe, aMemAddr, aMemWdata, aIfRvalid, aDmRvalid, aIfRdata, aDmRdata);
      monitor(1, bIfGnt, bDmGnt, bMemEn, bMemWe, bMemAddr, bMemWdata, bIfRvalid, bDmRvalid, bIfRdata, bDmRdata);
   end

   // Instance B: back-to-back loads with single-cycle memory.
   initial begin
      bRst = 1'b1; bIfReq = 1'b0; bIfAddr = '0; bDmReq = 1'b0; bDmWe = 1'b0; bDmAddr = '0; bDmWdata = '0;
      at(3);
      bRst = 1'b0;
      at(4);
      bDmReq = 1'b1; bDmAddr = 32'h80;
      pushGnt(1, 4, 1'b0, 1'b0, 32'h80, 32'h0);
      pushRsp(1, 6, 1'b0, 32'hA0A0A0A0);
      at(5);
      bDmAddr = 32'h84;
      pushGnt(1, 6, 1'b0, 1'b0, 32'h84, 32'h0);
      pushRsp(1, 8, 1'b0, 32'hB1B1B1B1);
      at(7);
      bDmReq = 1'b0;
   end

   initial begin
      int  sc[7] = '{20, 23, 26, 29, 32, 35, 38};
      bit  si[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      aRst = 1'b1; aIfReq = 1'b0; aIfAddr = '0; aDmReq = 1'b0; aDmWe = 1'b0; aDmAddr = '0; aDmWdata = '0;
      at(2);
      aIfReq = 1'b1; aIfAddr = 32'h100;
      @(negedge clk);
      chk("reset busy", 128'(aBusy), 128'(0));
      chk("reset rvalid", 128'({aIfRvalid, aDmRvalid}), 128'(0));
      chk("reset rdata", 128'({aIfRdata, aDmRdata}), 128'(0));

      // Fetch-only read granted the first cycle out of reset.
      at(3);
      aRst = 1'b0;
      pushGnt(0, 3, 1'b1, 1'b0, 32'h100, 32'h0);
      pushRsp(0, 6, 1'b1, 32'hDEADBEEF);
      at(4);
      aIfReq = 1'b0;
      at(5);
      aIfReq = 1'b1; aIfAddr = 32'h104;
      pushGnt(0, 6, 1'b1, 1'b0, 32'h104, 32'h0);
      pushRsp(0, 9, 1'b1, 32'h55556666);
      at(7);
      aIfReq = 1'b0;

      // Store: ack next cycle, dm_rdata keeps its reset value.
      at(10);
      aDmReq = 1'b1; aDmWe = 1'b1; aDmAddr = 32'h40; aDmWdata = 32'h12345678;
      pushGnt(0, 10, 1'b0, 1'b1, 32'h40, 32'h12345678);
      pushRsp(0, 11, 1'b0, 32'h0);
      at(11);
      aDmReq = 1'b0; aDmWe = 1'b0; aDmWdata = '0;

      // Fetch arriving during a data read waits until the read returns.
      at(13);
      aDmReq = 1'b1; aDmAddr = 32'h200;
      pushGnt(0, 13, 1'b0, 1'b0, 32'h200, 32'h0);
      pushRsp(0, 16, 1'b0, 32'h11112222);
      at(14);
      aDmReq = 1'b0; aIfReq = 1'b1; aIfAddr = 32'h300;
      pushGnt(0, 16, 1'b1, 1'b0, 32'h300, 32'h0);
      pushRsp(0, 19, 1'b1, 32'h33334444);
      at(17);
      aIfReq = 1'b0;

      // Both ports requesting continuously: four data wins, then fetch once.
      at(20);
      aIfReq = 1'b1; aIfAddr = 32'h104; aDmReq = 1'b1; aDmAddr = 32'h40;
      for (int i = 0; i < 7; i++) begin
         pushGnt(0, sc[i], si[i], 1'b0, si[i] ? 32'h104 : 32'h40, 32'h0);
         pushRsp(0, sc[i] + 3, si[i], si[i] ? 32'h55556666 : 32'h12345678);
      end
      at(36);
      aDmReq = 1'b0;
      at(39);
      aIfReq = 1'b0;

      // Reset during a read abandons it; a pending fetch goes first after reset.
      at(42);
      aDmReq = 1'b1; aDmAddr = 32'h200;
      pushGnt(0, 42, 1'b0, 1'b0, 32'h200, 32'h0);
      at(43);
      aDmReq = 1'b0; aRst = 1'b1; aIfReq = 1'b1; aIfAddr = 32'h100;
      pushGnt(0, 44, 1'b1, 1'b0, 32'h100, 32'h0);
      pushRsp(0, 47, 1'b1, 32'hDEADBEEF);
      at(44);
      aRst = 1'b0;
      @(negedge clk);
      chk("busy after reset", 128'(aBusy), 128'(0));
      chk("rdata after reset", 128'({aIfRdata, aDmRdata}), 128'(0));
      at(45);
      aIfReq = 1'b0;

      at(60);
      chk("A grants never seen", 128'(qGA.size()), 128'(0));
      chk("A responses never seen", 128'(qRA.size()), 128'(0));
      chk("B grants never seen", 128'(qGB.size()), 128'(0));
      chk("B responses never seen", 128'(qRB.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
